battle_sequencer: RTL and testbench
===================================

Name: battle_sequencer

Overview:
- Turn-based combat controller for the dungeon engine.
- Started by the map/movement logic when the player steps onto an enemy tile.
- Owns the enemy and player HP registers for the duration of an encounter and sequences each turn: accept command, player strike or run attempt, enemy strike, death checks.
- Reports win/lose/fled back to the engine, which resumes map display and movement.

Parameters:
- HP_W, 16, width of all HP values.
- PLAYER_ATK, 10, fixed player damage per attack.
- SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- encounter  in  1  start pulse; honoured only in IDLE.
- player_hp_in  in  HP_W  player HP, sampled on encounter.
- enemy_hp_init  in  HP_W  enemy starting HP, sampled on encounter.
- enemy_atk  in  8  enemy damage per hit; zero-extended, read live.
- godmode  in  1  suppresses enemy damage; read live.
- cmd_valid  in  1  command strobe.
- cmd  in  4  command code: 5 = attack, 6 = run; all other codes are ignored.
- cmd_ready  out  1  high only in WAIT_CMD.
- player_hp  out  HP_W  current player HP.
- enemy_hp  out  HP_W  current enemy HP.
- in_battle  out  1  high from the edge sampling encounter until the terminal state is entered.
- run_failed  out  1  one-cycle pulse on a failed run.
- done  out  1  high for exactly one cycle, while in a terminal state.
- result  out  2  encounter outcome: 0 none, 1 win, 2 lose, 3 fled; held until the next encounter.

Behaviour:
- Reset (asynchronous, immediate, any state): state = IDLE; player_hp, enemy_hp, result = 0; cmd_ready, in_battle, run_failed, done = 0; lfsr = SEED.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left every clock in every state. The run decision uses lfsr[1:0] as registered at the accepting edge.
- States: IDLE, WAIT_CMD, PLAYER_HIT, CHECK_E, RUN, ENEMY_HIT, CHECK_P, WIN, LOSE, FLED.
- IDLE, encounter=1:
  - Load player_hp and enemy_hp; clear result; set in_battle.
  - Go to WAIT_CMD, or straight to WIN if enemy_hp_init == 0.
  - player_hp_in == 0 is treated as a normal start; loss is detected at the first CHECK_P.
- WAIT_CMD: cmd_ready = 1.
  - cmd_valid with cmd 5 -> PLAYER_HIT.
  - cmd_valid with cmd 6 -> RUN.
  - cmd_valid with any other code: consumed, no effect, stay in WAIT_CMD.
- PLAYER_HIT: enemy_hp <= enemy_hp saturating-minus PLAYER_ATK (floors at 0, never wraps) -> CHECK_E.
- CHECK_E: enemy_hp == 0 -> WIN, else -> ENEMY_HIT.
- RUN:
  - lfsr[1:0] != 0 -> FLED.
  - Otherwise pulse run_failed for this cycle -> ENEMY_HIT (a failed run costs the turn).
- ENEMY_HIT: if !godmode, player_hp <= player_hp saturating-minus enemy_atk -> CHECK_P.
- CHECK_P: player_hp == 0 -> LOSE, else -> WAIT_CMD.
- WIN / LOSE / FLED:
  - On entry: result set to 1 / 2 / 3; in_battle cleared.
  - done = 1 during this state only; next state IDLE.
  - HP outputs hold their final values until the next encounter.
- Latency:
  - Attack accepted at edge E0: enemy_hp updates at E1, player_hp at E3, cmd_ready returns high after E4.
  - Run accepted at E0: FLED entered at E1.
- Ignored inputs:
  - encounter outside IDLE, including during terminal states.
  - cmd_valid outside WAIT_CMD.
- Simultaneous events: reset dominates everything.
- Throughput: at most one command per turn; no command queueing.

Test Plan:
- Win path: reset; encounter with player 100, enemy 25, atk 10; three attacks.
  - Expect enemy_hp 15, 5, 0; player_hp 90, 80, then unchanged.
  - Expect result=1 and a one-cycle done pulse 2 cycles after the third accept; cmd_ready high 4 cycles after accepts 1 and 2.
- Lose path with saturation: player 15, enemy 100, atk 20; one attack.
  - Expect enemy_hp 90 and player_hp 0 (no wrap).
  - Expect LOSE, result=2, done pulse; cmd_ready stays low.
- Godmode: godmode=1; player 100, enemy 30, atk 50; three attacks.
  - Expect player_hp stays 100; result=1.
- Run: bench LFSR model predicts lfsr[1:0] at each accept.
  - Accept where lfsr[1:0]==0: expect run_failed pulse, player_hp 100->90, return to WAIT_CMD.
  - Accept where lfsr[1:0]!=0: expect result=3 one cycle later, HP unchanged.
- Ignores and edge cases:
  - cmd 7 in WAIT_CMD: no HP change, still ready.
  - cmd_valid during ENEMY_HIT: ignored.
  - encounter mid-battle: HP not reloaded.
  - enemy_hp_init=0: WIN on the next cycle.
- Reset mid-battle: assert rst while in ENEMY_HIT.
  - Expect all outputs 0 immediately, without waiting for a clock.
  - After release: IDLE; a new encounter starts cleanly.

Source files
------------

// File: rtl/battle_sequencer.sv
// Turn-based combat controller: owns player/enemy HP for one encounter and
// sequences command, player strike or run attempt, enemy strike and death checks.
module battle_sequencer #(
    parameter int          HP_W       = 16,
    parameter int          PLAYER_ATK = 10,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            encounter,
    input  logic [HP_W-1:0] player_hp_in,
    input  logic [HP_W-1:0] enemy_hp_init,
    input  logic [7:0]      enemy_atk,
    input  logic            godmode,
    input  logic            cmd_valid,
    input  logic [3:0]      cmd,
    output logic            cmd_ready,
    output logic [HP_W-1:0] player_hp,
    output logic [HP_W-1:0] enemy_hp,
    output logic            in_battle,
    output logic            run_failed,
    output logic            done,
    output logic [1:0]      result
);

    localparam logic [15:0]     LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [HP_W-1:0] ATK       = HP_W'(PLAYER_ATK);
    localparam logic [3:0]      CMD_ATK   = 4'd5;
    localparam logic [3:0]      CMD_RUN   = 4'd6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_CMD,
        S_PLAYER_HIT,
        S_CHECK_E,
        S_RUN,
        S_ENEMY_HIT,
        S_CHECK_P,
        S_WIN,
        S_LOSE,
        S_FLED
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_lfsr;
    logic [HP_W-1:0] r_player_hp;
    logic [HP_W-1:0] r_enemy_hp;
    logic            r_in_battle;
    logic [1:0]      r_result;
    logic            w_cmd_ready;
    logic            w_run_failed;
    logic            w_done;
    logic            w_lfsr_fb;
    logic [HP_W-1:0] w_enemy_dmg;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                 input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_enemy_dmg = HP_W'(enemy_atk);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_ready  = 1'b0;
        w_run_failed = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (encounter) begin
                    w_state_nxt = (enemy_hp_init == '0) ? S_WIN : S_WAIT_CMD;
                end
            end
            S_WAIT_CMD: begin
                w_cmd_ready = 1'b1;
                // Unknown codes are consumed silently and the turn keeps waiting.
                if (cmd_valid && cmd == CMD_ATK) begin
                    w_state_nxt = S_PLAYER_HIT;
                end else if (cmd_valid && cmd == CMD_RUN) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_PLAYER_HIT: w_state_nxt = S_CHECK_E;
            S_CHECK_E:    w_state_nxt = (r_enemy_hp == '0) ? S_WIN : S_ENEMY_HIT;
            S_RUN: begin
                // r_lfsr here is the value loaded at the edge that accepted the run.
                if (r_lfsr[1:0] != 2'b00) begin
                    w_state_nxt = S_FLED;
                end else begin
                    w_run_failed = 1'b1;
                    w_state_nxt  = S_ENEMY_HIT;
                end
            end
            S_ENEMY_HIT:  w_state_nxt = S_CHECK_P;
            S_CHECK_P:    w_state_nxt = (r_player_hp == '0) ? S_LOSE : S_WAIT_CMD;
            S_WIN, S_LOSE, S_FLED: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr      <= LFSR_INIT;
            r_player_hp <= '0;
            r_enemy_hp  <= '0;
            r_in_battle <= 1'b0;
            r_result    <= 2'd0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            if (r_state == S_IDLE && encounter) begin
                r_player_hp <= player_hp_in;
                r_enemy_hp  <= enemy_hp_init;
                r_in_battle <= 1'b1;
                r_result    <= 2'd0;
            end
            if (r_state == S_PLAYER_HIT) begin
                r_enemy_hp <= sat_sub(r_enemy_hp, ATK);
            end
            if (r_state == S_ENEMY_HIT && !godmode) begin
                r_player_hp <= sat_sub(r_player_hp, w_enemy_dmg);
            end
            // Terminal entry overrides the IDLE load so an empty enemy wins at once.
            if (w_state_nxt == S_WIN) begin
                r_result    <= 2'd1;
                r_in_battle <= 1'b0;
            end else if (w_state_nxt == S_LOSE) begin
                r_result    <= 2'd2;
                r_in_battle <= 1'b0;
            end else if (w_state_nxt == S_FLED) begin
                r_result    <= 2'd3;
                r_in_battle <= 1'b0;
            end
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign run_failed = w_run_failed;
    assign done       = w_done;
    assign player_hp  = r_player_hp;
    assign enemy_hp   = r_enemy_hp;
    assign in_battle  = r_in_battle;
    assign result     = r_result;

endmodule

// File: tb/tb_battle_sequencer.sv
// Scoreboard bench for battle_sequencer: stimulus queues expected events,
// a monitor pops them on done, run_failed and cmd_ready rising.
module tb_battle_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        encounter = 1'b0;
    logic [15:0] player_hp_in = '0;
    logic [15:0] enemy_hp_init = '0;
    logic [7:0]  enemy_atk = '0;
    logic        godmode = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd = '0;
    logic        cmd_ready;
    logic [15:0] player_hp;
    logic [15:0] enemy_hp;
    logic        in_battle;
    logic        run_failed;
    logic        done;
    logic [1:0]  result;

    battle_sequencer #(.HP_W(16), .PLAYER_ATK(10), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .encounter(encounter),
        .player_hp_in(player_hp_in), .enemy_hp_init(enemy_hp_init),
        .enemy_atk(enemy_atk), .godmode(godmode),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .player_hp(player_hp), .enemy_hp(enemy_hp), .in_battle(in_battle),
        .run_failed(run_failed), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int res;
        int php;
        int ehp;
    } exp_t;

    exp_t        q_done[$];
    exp_t        q_rdy[$];
    exp_t        q_rf[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] lfsr_m;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic exp_t mk(input int c, input int r, input int p, input int e);
        exp_t x;
        x.cyc = c;
        x.res = r;
        x.php = p;
        x.ehp = e;
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= lfsr_next(lfsr_m);
    end

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor
    initial begin
        bit   prev_ready;
        exp_t x;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ready = 1'b0;
            end else begin
                if (done) begin
                    chk("done_expected", int'(q_done.size() > 0), 1);
                    if (q_done.size() > 0) begin
                        x = q_done.pop_front();
                        chk("done_cycle", cyc, x.cyc);
                        chk("done_result", result, x.res);
                        chk("done_player_hp", player_hp, x.php);
                        chk("done_enemy_hp", enemy_hp, x.ehp);
                        chk("done_in_battle", in_battle, 0);
                    end
                end
                if (run_failed) begin
                    chk("run_failed_expected", int'(q_rf.size() > 0), 1);
                    if (q_rf.size() > 0) begin
                        x = q_rf.pop_front();
                        chk("run_failed_cycle", cyc, x.cyc);
                        chk("run_failed_player_hp", player_hp, x.php);
                        chk("run_failed_enemy_hp", enemy_hp, x.ehp);
                    end
                end
                if (cmd_ready && !prev_ready) begin
                    chk("ready_expected", int'(q_rdy.size() > 0), 1);
                    if (q_rdy.size() > 0) begin
                        x = q_rdy.pop_front();
                        chk("ready_cycle", cyc, x.cyc);
                        chk("ready_player_hp", player_hp, x.php);
                        chk("ready_enemy_hp", enemy_hp, x.ehp);
                        chk("ready_in_battle", in_battle, 1);
                    end
                end
                prev_ready = cmd_ready;
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic start(input int p, input int e, input int atk, input bit god);
        int k;
        int n;
        k = 0;
        while ((in_battle || done) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_before_start", int'(in_battle || done), 0);
        player_hp_in  = 16'(p);
        enemy_hp_init = 16'(e);
        enemy_atk     = 8'(atk);
        godmode       = god;
        encounter     = 1'b1;
        n = cyc;
        if (e != 0) q_rdy.push_back(mk(n + 1, 0, p, e));
        else        q_done.push_back(mk(n + 1, 1, p, 0));
        @(negedge clk);
        encounter = 1'b0;
        chk("in_battle_on_start", in_battle, int'(e != 0));
        if (e != 0) chk("result_cleared", result, 0);
    endtask

    // kind: 0 battle continues, 1 win, 2 lose
    task automatic attack(input int kind, input int exp_e, input int exp_p, input bit inject);
        int n;
        wait_ready();
        cmd_valid = 1'b1;
        cmd       = 4'd5;
        n = cyc;
        if (kind == 0)      q_rdy.push_back(mk(n + 5, 0, exp_p, exp_e));
        else if (kind == 1) q_done.push_back(mk(n + 3, 1, exp_p, 0));
        else                q_done.push_back(mk(n + 5, 2, exp_p, exp_e));
        @(negedge clk);
        cmd_valid = 1'b0;
        if (inject) begin
            encounter     = 1'b1;
            player_hp_in  = 16'd999;
            enemy_hp_init = 16'd777;
        end
        repeat (2) @(negedge clk);
        if (inject) begin
            cmd_valid = 1'b1;
            cmd       = 4'd5;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        encounter = 1'b0;
    endtask

    task automatic run_try(input bit want_fail, input int p, input int e, input int atk);
        int          n;
        int          k;
        logic [15:0] nx;
        wait_ready();
        k  = 0;
        nx = lfsr_next(lfsr_m);
        while (((nx[1:0] == 2'b00) != want_fail) && k < 64) begin
            @(negedge clk);
            k++;
            nx = lfsr_next(lfsr_m);
        end
        chk("run_lfsr_search", int'(nx[1:0] == 2'b00), int'(want_fail));
        cmd_valid = 1'b1;
        cmd       = 4'd6;
        n = cyc;
        if (want_fail) begin
            q_rf.push_back(mk(n + 1, 0, p, e));
            q_rdy.push_back(mk(n + 4, 0, p - atk, e));
        end else begin
            q_done.push_back(mk(n + 2, 3, p, e));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_player_hp", player_hp, 0);
        chk("rst_enemy_hp", enemy_hp, 0);
        chk("rst_result", result, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_in_battle", in_battle, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Win path
        start(100, 25, 10, 1'b0);
        attack(0, 15, 90, 1'b0);
        attack(0, 5, 80, 1'b0);
        attack(1, 0, 80, 1'b0);

        // Lose path with saturating player damage
        start(15, 100, 20, 1'b0);
        attack(2, 90, 0, 1'b0);

        // Godmode
        start(100, 30, 50, 1'b1);
        attack(0, 20, 100, 1'b0);
        attack(0, 10, 100, 1'b0);
        attack(1, 0, 100, 1'b0);

        // Run: one failed attempt, then a successful escape
        start(100, 200, 10, 1'b0);
        run_try(1'b1, 100, 200, 10);
        run_try(1'b0, 90, 200, 10);

        // Ignored command code, mid-turn command and mid-battle encounter
        start(100, 100, 10, 1'b0);
        wait_ready();
        cmd_valid = 1'b1;
        cmd       = 4'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd7_still_ready", cmd_ready, 1);
        chk("cmd7_enemy_hp", enemy_hp, 100);
        chk("cmd7_player_hp", player_hp, 100);
        attack(0, 90, 90, 1'b1);
        attack(0, 80, 80, 1'b0);

        // Asynchronous reset while in ENEMY_HIT
        wait_ready();
        cmd_valid = 1'b1;
        cmd       = 4'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_turn_enemy_hp", enemy_hp, 70);
        chk("mid_turn_in_battle", in_battle, 1);
        #2;
        rst = 1'b1;
        q_rdy.delete();
        q_done.delete();
        q_rf.delete();
        #1;
        chk("async_rst_player_hp", player_hp, 0);
        chk("async_rst_enemy_hp", enemy_hp, 0);
        chk("async_rst_in_battle", in_battle, 0);
        chk("async_rst_result", result, 0);
        chk("async_rst_cmd_ready", cmd_ready, 0);
        chk("async_rst_run_failed", run_failed, 0);
        chk("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 0);
        chk("post_rst_in_battle", in_battle, 0);

        start(60, 20, 10, 1'b0);
        attack(0, 10, 50, 1'b0);
        attack(1, 0, 50, 1'b0);

        // Enemy already dead at encounter
        start(70, 0, 10, 1'b0);

        repeat (6) @(negedge clk);
        chk("pending_done", q_done.size(), 0);
        chk("pending_ready", q_rdy.size(), 0);
        chk("pending_run_failed", q_rf.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
